// File: rtl/pixel_bank_dispatcher.sv
// Pixel bank dispatcher: stores one image round-robin across NBANK banks and
// replays it on demand, all banks in parallel, any number of times.
module pixel_bank_dispatcher #(
  parameter int unsigned NBANK = 2,
  parameter int unsigned PIX_W = 24,
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW  = $clog2(DEPTH),
  localparam int unsigned BW  = $clog2(NBANK),
  localparam int unsigned PCW = AW + BW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [PIX_W-1:0]       in_pixel,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   start_pass,
  input  logic                   out_stall,
  output logic [NBANK-1:0]       out_valid,
  output logic [NBANK*PIX_W-1:0] out_pixel,
  output logic                   pass_done,
  output logic                   image_ready,
  output logic                   overflow,
  output logic [PCW-1:0]         pixel_count
);

  localparam int unsigned FW        = AW + 1;
  localparam logic [PCW-1:0] CAP    = PCW'(NBANK * DEPTH);
  localparam logic [BW-1:0] LAST_BANK = BW'(NBANK - 1);

  typedef enum logic [1:0] {FILL, READY, REPLAY} state_t;

  state_t        state;
  logic [BW-1:0] wr_bank;
  logic [FW-1:0] fill [NBANK];
  logic [FW-1:0] rd_addr;
  logic          accept_c;
  logic          step_c;
  logic          issue_c;

  assign in_ready = (state == FILL) && (pixel_count < CAP);
  assign accept_c = in_valid && in_ready;
  // Bank 0 always holds the most words, so its fill bounds the pass length.
  assign step_c   = (state == REPLAY) && !out_stall;
  assign issue_c  = step_c && (rd_addr < fill[0]);

  // Control: fill bookkeeping, replay address sequencing, status flags.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= FILL;
      wr_bank     <= '0;
      rd_addr     <= '0;
      pixel_count <= '0;
      overflow    <= 1'b0;
      pass_done   <= 1'b0;
      image_ready <= 1'b0;
      for (int b = 0; b < NBANK; b++) fill[b] <= '0;
    end else begin
      pass_done <= 1'b0;
      case (state)
        FILL: begin
          if (accept_c) begin
            pixel_count <= pixel_count + PCW'(1);
            for (int b = 0; b < NBANK; b++)
              if (wr_bank == BW'(b)) fill[b] <= fill[b] + FW'(1);
            wr_bank <= (wr_bank == LAST_BANK) ? '0 : wr_bank + BW'(1);
            if (in_last) begin
              state       <= READY;
              image_ready <= 1'b1;
            end
          end else if (in_valid) begin
            overflow <= 1'b1;
          end
        end
        READY: begin
          if (start_pass) begin
            state       <= REPLAY;
            rd_addr     <= '0;
            image_ready <= 1'b0;
          end
        end
        REPLAY: begin
          if (step_c) begin
            if (issue_c) begin
              rd_addr <= rd_addr + FW'(1);
            end else begin
              state       <= READY;
              pass_done   <= 1'b1;
              image_ready <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_addr;
    logic             hit_c;
    logic             vld;
    logic [PIX_W-1:0] pix;

    assign wr_addr = fill[b][AW-1:0];
    assign hit_c   = issue_c && (rd_addr < fill[b]);

    always_ff @(posedge clk) begin
      if (accept_c && (wr_bank == BW'(b))) mem[wr_addr] <= in_pixel;
    end

    // Read port: one-cycle latency, frozen by stall, pixel held when idle.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld <= 1'b0;
        pix <= '0;
      end else if (clear) begin
        vld <= 1'b0;
      end else if (step_c) begin
        vld <= hit_c;
        if (hit_c) pix <= mem[rd_addr[AW-1:0]];
      end
    end

    assign out_valid[b]                = vld;
    assign out_pixel[b*PIX_W +: PIX_W] = pix;
  end

endmodule

// File: tb/tb_pixel_bank_dispatcher.sv
// Bench: two dispatcher configurations (2x8 and 4x4, both 16 pixels) share
// one stimulus stream and are each checked against an image-level model.
module tb_pixel_bank_dispatcher;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_last, start_pass, out_stall;
  logic [23:0] in_pixel;

  logic        ready_a, pd_a, ir_a, ovf_a;
  logic [1:0]  vld_a;
  logic [47:0] pix_a;
  logic [4:0]  cnt_a;
  logic        ready_b, pd_b, ir_b, ovf_b;
  logic [3:0]  vld_b;
  logic [95:0] pix_b;
  logic [4:0]  cnt_b;

  always #5 clk = ~clk;

  pixel_bank_dispatcher #(.NBANK(2), .PIX_W(24), .DEPTH(8)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_last(in_last), .in_ready(ready_a),
    .start_pass(start_pass), .out_stall(out_stall), .out_valid(vld_a),
    .out_pixel(pix_a), .pass_done(pd_a), .image_ready(ir_a),
    .overflow(ovf_a), .pixel_count(cnt_a));

  pixel_bank_dispatcher #(.NBANK(4), .PIX_W(24), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_last(in_last), .in_ready(ready_b),
    .start_pass(start_pass), .out_stall(out_stall), .out_valid(vld_b),
    .out_pixel(pix_b), .pass_done(pd_b), .image_ready(ir_b),
    .overflow(ovf_b), .pixel_count(cnt_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beats [2][4];
  int dones [2];
  int done_cyc [2];

  // Model: stored image as a pixel list; replay position as a beat index.
  int          mst [2];
  int          mcnt [2];
  int          mbeat [2];
  logic [23:0] img [2][16];
  bit          movf [2];
  bit          mpd [2];
  bit          mir [2];
  bit          mvld [2][4];
  logic [23:0] mpix [2][4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int nb_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  // Pixels k with k mod nb == b.
  function automatic int fill_of(input int i, input int b);
    int nb;
    nb = nb_of(i);
    return (mcnt[i] + nb - 1 - b) / nb;
  endfunction

  task automatic model_update(input int i);
    int nb;
    nb = nb_of(i);
    if (reset) begin
      mst[i] = 0; mcnt[i] = 0; mbeat[i] = 0;
      movf[i] = 0; mpd[i] = 0; mir[i] = 0;
      for (int b = 0; b < 4; b++) begin mvld[i][b] = 0; mpix[i][b] = '0; end
    end else if (clear) begin
      mst[i] = 0; mcnt[i] = 0; mbeat[i] = 0;
      movf[i] = 0; mpd[i] = 0; mir[i] = 0;
      for (int b = 0; b < 4; b++) mvld[i][b] = 0;
    end else begin
      mpd[i] = 0;
      case (mst[i])
        0: if (in_valid) begin
          if (mcnt[i] < 16) begin
            img[i][mcnt[i]] = in_pixel;
            mcnt[i]++;
            if (in_last) begin mst[i] = 1; mir[i] = 1; end
          end else begin
            movf[i] = 1;
          end
        end
        1: if (start_pass) begin mst[i] = 2; mbeat[i] = 0; mir[i] = 0; end
        default: if (!out_stall) begin
          if (mbeat[i] < fill_of(i, 0)) begin
            for (int b = 0; b < nb; b++) begin
              mvld[i][b] = mbeat[i] < fill_of(i, b);
              if (mvld[i][b]) mpix[i][b] = img[i][mbeat[i] * nb + b];
            end
            mbeat[i]++;
          end else begin
            for (int b = 0; b < 4; b++) mvld[i][b] = 0;
            mst[i] = 1; mpd[i] = 1; mir[i] = 1;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic       rdy, pdo, iro, ovo;
    logic [4:0] co;
    logic [3:0] vo, ev;
    logic [23:0] po;
    string      nm;
    for (int i = 0; i < 2; i++) begin
      nm  = (i == 0) ? "A" : "B";
      rdy = (i == 0) ? ready_a : ready_b;
      pdo = (i == 0) ? pd_a : pd_b;
      iro = (i == 0) ? ir_a : ir_b;
      ovo = (i == 0) ? ovf_a : ovf_b;
      co  = (i == 0) ? cnt_a : cnt_b;
      vo  = (i == 0) ? {2'b00, vld_a} : vld_b;
      for (int b = 0; b < 4; b++) ev[b] = mvld[i][b];
      chk($sformatf("%s.in_ready@%0d", nm, cyc), 64'(rdy),
          64'((mst[i] == 0) && (mcnt[i] < 16)));
      chk($sformatf("%s.pass_done@%0d", nm, cyc), 64'(pdo), 64'(mpd[i]));
      chk($sformatf("%s.image_ready@%0d", nm, cyc), 64'(iro), 64'(mir[i]));
      chk($sformatf("%s.overflow@%0d", nm, cyc), 64'(ovo), 64'(movf[i]));
      chk($sformatf("%s.pixel_count@%0d", nm, cyc), 64'(co), 64'(mcnt[i]));
      chk($sformatf("%s.out_valid@%0d", nm, cyc), 64'(vo), 64'(ev));
      for (int b = 0; b < nb_of(i); b++) begin
        po = (i == 0) ? pix_a[b*24 +: 24] : pix_b[b*24 +: 24];
        chk($sformatf("%s.out_pixel%0d@%0d", nm, b, cyc), 64'(po), 64'(mpix[i][b]));
      end
      if (pdo) begin dones[i]++; done_cyc[i] = cyc; end
    end
  endtask

  // One clock: tally delivered beats, advance model, check at negedge.
  task automatic step();
    for (int b = 0; b < 2; b++) if (vld_a[b] && !out_stall) beats[0][b]++;
    for (int b = 0; b < 4; b++) if (vld_b[b] && !out_stall) beats[1][b]++;
    @(posedge clk);
    cyc++;
    model_update(0);
    model_update(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    clear = 0; in_valid = 0; in_last = 0; start_pass = 0; out_stall = 0; in_pixel = '0;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      dones[i] = 0; done_cyc[i] = 0;
      for (int b = 0; b < 4; b++) beats[i][b] = 0;
    end
  endtask

  task automatic push(input logic [23:0] p, input logic l);
    in_valid = 1; in_pixel = p; in_last = l;
    step();
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 100; n++) begin
      step();
      if (ir_a && ir_b) return;
    end
    chk("wait_ready_timeout", 64'(0), 64'(1));
  endtask

  int start_cyc;

  initial begin
    idle();
    reset = 1;
    clr_counts();
    step(); step();
    reset = 0;

    // Ignored controls in FILL.
    start_pass = 1; in_last = 1;
    step(); step();
    idle();
    step();
    chk("fill_hold_ready", 64'(ir_a | ir_b), 64'(0));

    // Five pixels 1..5, one pass.
    clr_counts();
    for (int k = 1; k <= 5; k++) push(24'(k), k == 5);
    start_pass = 1; step(); start_pass = 0;
    wait_ready();
    chk("A.beats0", 64'(beats[0][0]), 64'(3));
    chk("A.beats1", 64'(beats[0][1]), 64'(2));
    chk("B.beats0", 64'(beats[1][0]), 64'(2));
    chk("B.beats3", 64'(beats[1][3]), 64'(1));
    chk("A.dones5", 64'(dones[0]), 64'(1));
    chk("B.dones5", 64'(dones[1]), 64'(1));

    // Full image with a 3-cycle stall mid-pass.
    clear = 1; step(); clear = 0;
    for (int k = 0; k < 16; k++) push(24'($urandom), k == 15);
    chk("A.ovf_full_last", 64'(ovf_a), 64'(0));
    clr_counts();
    start_pass = 1; step(); start_pass = 0;
    start_cyc = cyc;
    step(); step(); step();
    out_stall = 1; step(); step(); step(); out_stall = 0;
    wait_ready();
    chk("A.stall_beats", 64'(beats[0][0] + beats[0][1]), 64'(16));
    chk("B.stall_beats", 64'(beats[1][0] + beats[1][1] + beats[1][2] + beats[1][3]), 64'(16));
    chk("A.stall_done_at", 64'(done_cyc[0] - start_cyc), 64'(8 + 1 + 3));
    chk("B.stall_done_at", 64'(done_cyc[1] - start_cyc), 64'(4 + 1 + 3));

    // Back-to-back passes.
    clr_counts();
    start_pass = 1;
    for (int n = 0; n < 200 && dones[0] < 3; n++) step();
    start_pass = 0;
    wait_ready();
    chk("A.dones3", 64'(dones[0]), 64'(3));
    chk("A.beats3pass", 64'(beats[0][1]), 64'(24));
    chk("B.dones_ge3", 64'(dones[1] >= 3), 64'(1));

    // Clear mid-replay.
    clr_counts();
    start_pass = 1; step(); start_pass = 0;
    step(); step(); step();
    clear = 1; step(); clear = 0;
    chk("A.clear_valid", 64'(vld_a), 64'(0));
    chk("A.clear_count", 64'(cnt_a), 64'(0));
    step(); step();
    chk("A.clear_nodone", 64'(dones[0]), 64'(0));

    // Overflow: 17 offered, 16 taken; unaccepted in_last ignored.
    for (int k = 0; k < 17; k++) push(24'(k + 100), 1'b0);
    chk("B.ovf_17", 64'(ovf_b), 64'(1));
    chk("B.cnt_17", 64'(cnt_b), 64'(16));
    push(24'h0, 1'b1);
    chk("B.no_ready_full", 64'(ir_b), 64'(0));
    clear = 1; step(); clear = 0;
    chk("B.ovf_cleared", 64'(ovf_b), 64'(0));

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      reset      = ($urandom_range(499) == 0);
      clear      = ($urandom_range(149) == 0);
      in_valid   = ($urandom_range(2) != 0);
      in_pixel   = 24'($urandom);
      in_last    = ($urandom_range(9) == 0);
      start_pass = ($urandom_range(3) == 0);
      out_stall  = ($urandom_range(3) == 0);
      step();
    end
    idle();
    reset = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
